dac_stream_prebuf: RTL and testbench

Elastic pre-fill buffer between the DAC data path's 256-bit AXI4-Stream output and the RF data converter DAC AXIS input, in the `rf_clk` domain. It absorbs DDR/AXI read jitter by holding output until a programmable fill level is reached. It then streams gap-free to the DAC, inserting zero words on underflow and re-priming afterwards. It reports fill level, state and underflow count for debug registers.

---
 rtl/dac_stream_prebuf_if.sv | 13 +
 rtl/dac_stream_prebuf.sv | 160 ++++++++++++++++
 tb/tb_dac_stream_prebuf.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dac_stream_prebuf_if.sv
// Stream bundle (data/valid/ready) for the DAC pre-fill buffer ports.
// Latency: none, wires only.
// Backpressure: tready flows from slave to master; tdata/tvalid flow master to slave.
interface dac_stream_prebuf_if #(
  parameter int DATA_WIDTH = 256
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/dac_stream_prebuf.sv
// Elastic pre-fill buffer: holds DAC words until a fill threshold is met, then streams gap-free, inserting zeros on underflow.
// Latency: 1 cycle plus FIFO occupancy from input to output register; threshold check adds 1 cycle when priming.
// Backpressure: input ready only in PREFILL/RUN with room; output register only advances when m_axis.tready (or idle).
// Optional feature macro: DAC_STREAM_UNDERFLOW_CNT_EN enables the underflow counter and sticky flag.
module dac_stream_prebuf #(
  parameter  int DATA_WIDTH = 256,
  parameter  int DEPTH      = 64,
  parameter  int CNT_WIDTH  = 32,
  localparam int LVL_W      = $clog2(DEPTH) + 1
) (
  input  logic                  rf_clk,
  input  logic                  rf_rstb,
  input  logic                  enable,
  input  logic [LVL_W-1:0]      prefill_thresh,
  input  logic                  underflow_clr,
  dac_stream_prebuf_if.slave    s_axis,
  dac_stream_prebuf_if.master   m_axis,
  output logic [LVL_W-1:0]      fill_level,
  output logic [1:0]            state,
  output logic [CNT_WIDTH-1:0]  underflow_cnt,
  output logic                  underflow_sticky
);

  localparam int               AW      = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PREFILL = 2'd1,
    RUN     = 2'd2,
    DRAIN   = 2'd3
  } state_e;

  state_e                cur;
  state_e                nxt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LVL_W-1:0]      level;
  logic [LVL_W-1:0]      eff_thresh;
  logic [DATA_WIDTH-1:0] out_dat;
  logic                  push;
  logic                  pop;
  logic                  upd;
  logic                  underflow;
  logic                  flush;

  // Clamp the programmed threshold into 1..DEPTH so RUN is always reachable.
  always_comb begin
    eff_thresh = prefill_thresh;
    if (prefill_thresh == '0) begin
      eff_thresh = LVL_W'(1);
    end else if (prefill_thresh > DEPTH_L) begin
      eff_thresh = DEPTH_L;
    end
  end

  // Output register advances whenever downstream takes a word or nothing is being offered.
  assign upd       = m_axis.tready || (cur == IDLE);
  assign push      = s_axis.tvalid && s_axis.tready;
  assign pop       = upd && ((cur == RUN) || (cur == DRAIN)) && (level != '0);
  // Decided on the pre-edge level, so a same-cycle push still counts as an underflow.
  assign underflow = (cur == RUN) && enable && (level == '0) && m_axis.tready;
  // Any entry to (or stay in) IDLE discards buffered data.
  assign flush     = (nxt == IDLE);

  // State register.
  always_ff @(posedge rf_clk) begin
    if (!rf_rstb) begin
      cur <= IDLE;
    end else begin
      cur <= nxt;
    end
  end

  // Next-state logic; dropping enable has priority over underflow in RUN.
  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:    if (enable) nxt = PREFILL;
      PREFILL: begin
        if (!enable)                   nxt = IDLE;
        else if (level >= eff_thresh)  nxt = RUN;
      end
      RUN: begin
        if (!enable)        nxt = DRAIN;
        else if (underflow) nxt = PREFILL;
      end
      DRAIN:   if (upd && (level == '0)) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from registered state and level.
  always_comb begin
    s_axis.tready = ((cur == PREFILL) || (cur == RUN)) && (level < DEPTH_L);
    m_axis.tvalid = (cur != IDLE);
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the level unchanged.
  always_ff @(posedge rf_clk) begin
    if (!rf_rstb || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge rf_clk) begin
    if (push) mem[wr_ptr] <= s_axis.tdata;
  end

  // Output register: FIFO head on a pop, otherwise a zero filler word.
  always_ff @(posedge rf_clk) begin
    if (!rf_rstb) begin
      out_dat <= '0;
    end else if (upd) begin
      out_dat <= pop ? mem[rd_ptr] : '0;
    end
  end

  assign m_axis.tdata = out_dat;
  assign fill_level   = level;
  assign state        = cur;

`ifdef DAC_STREAM_UNDERFLOW_CNT_EN
  logic [CNT_WIDTH-1:0] cnt;
  logic                 sticky;

  // Saturating underflow counter; a clear wins over a same-cycle increment.
  always_ff @(posedge rf_clk) begin
    if (!rf_rstb || underflow_clr) begin
      cnt    <= '0;
      sticky <= 1'b0;
    end else if (underflow) begin
      if (cnt != '1) cnt <= cnt + CNT_WIDTH'(1);
      sticky <= 1'b1;
    end
  end

  assign underflow_cnt    = cnt;
  assign underflow_sticky = sticky;
`else
  logic unused_clr;

  assign unused_clr       = underflow_clr;
  assign underflow_cnt    = '0;
  assign underflow_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_dac_stream_prebuf.sv
// Directed bench for dac_stream_prebuf: stream, backpressure, full, drain, underflow and reset scenarios.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Counter expectations follow DAC_STREAM_UNDERFLOW_CNT_EN (zero when the feature is compiled out).
module tb_dac_stream_prebuf;

  localparam int DW    = 256;
  localparam int DEPTH = 64;
  localparam int CW    = 32;
  localparam int LVL_W = 7;
`ifdef DAC_STREAM_UNDERFLOW_CNT_EN
  localparam int CE = 1;
`else
  localparam int CE = 0;
`endif

  logic             rf_clk = 1'b0;
  logic             rf_rstb;
  logic             enable;
  logic [LVL_W-1:0] prefill_thresh;
  logic             underflow_clr;
  logic [LVL_W-1:0] fill_level;
  logic [1:0]       state;
  logic [CW-1:0]    underflow_cnt;
  logic             underflow_sticky;

  dac_stream_prebuf_if #(.DATA_WIDTH(DW)) s_if ();
  dac_stream_prebuf_if #(.DATA_WIDTH(DW)) m_if ();

  dac_stream_prebuf #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .CNT_WIDTH  (CW)
  ) dut (
    .rf_clk           (rf_clk),
    .rf_rstb          (rf_rstb),
    .enable           (enable),
    .prefill_thresh   (prefill_thresh),
    .underflow_clr    (underflow_clr),
    .s_axis           (s_if),
    .m_axis           (m_if),
    .fill_level       (fill_level),
    .state            (state),
    .underflow_cnt    (underflow_cnt),
    .underflow_sticky (underflow_sticky)
  );

  always #5 rf_clk = ~rf_clk;

  int ncmp = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge rf_clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, DW'(state), DW'(0));
    chk({tag, "_fill"}, DW'(fill_level), DW'(0));
    chk({tag, "_mdata"}, m_if.tdata, DW'(0));
    chk({tag, "_mvalid"}, DW'(m_if.tvalid), DW'(0));
    chk({tag, "_sready"}, DW'(s_if.tready), DW'(0));
    chk({tag, "_cnt"}, DW'(underflow_cnt), DW'(0));
    chk({tag, "_sticky"}, DW'(underflow_sticky), DW'(0));
  endtask

  logic [DW-1:0] rxq [$];
  logic [DW-1:0] td_prev;
  logic          tr_prev;
  logic          tv_prev;
  logic          acc;
  int            idx;

  initial begin
    rf_rstb        = 1'b0;
    enable         = 1'b0;
    prefill_thresh = LVL_W'(4);
    underflow_clr  = 1'b0;
    s_if.tdata     = '0;
    s_if.tvalid    = 1'b0;
    m_if.tready    = 1'b0;

    // Reset state.
    tick;
    tick;
    chk_reset_vals("rst0");
    rf_rstb = 1'b1;

    // Basic stream: enable latency, then 10 words with thresh=4.
    m_if.tready = 1'b1;
    enable      = 1'b1;
    tick;
    chk("en_state", DW'(state), DW'(1));
    chk("en_sready", DW'(s_if.tready), DW'(1));
    for (int n = 1; n <= 16; n++) begin
      s_if.tvalid = (n <= 10);
      s_if.tdata  = DW'(n);
      tick;
      if (n == 4) chk("basic_prefill", DW'(state), DW'(1));
      if (n == 5) chk("basic_run", DW'(state), DW'(2));
      chk("basic_word", m_if.tdata, (n <= 5 || n > 15) ? DW'(0) : DW'(n - 5));
    end
    chk("basic_uf_state", DW'(state), DW'(1));
    chk("basic_uf_cnt", DW'(underflow_cnt), DW'(CE));

    // Backpressure: tready toggles each cycle, 20 words.
    idx = 0;
    for (int c = 0; c < 70; c++) begin
      s_if.tvalid = (idx < 20);
      s_if.tdata  = DW'(101 + idx);
      m_if.tready = c[0];
      if (m_if.tvalid && m_if.tready && (m_if.tdata != '0)) rxq.push_back(m_if.tdata);
      acc     = s_if.tvalid && s_if.tready;
      tr_prev = m_if.tready;
      tv_prev = m_if.tvalid;
      td_prev = m_if.tdata;
      tick;
      if (acc) idx++;
      if (!tr_prev && tv_prev) chk("bp_hold", m_if.tdata, td_prev);
    end
    s_if.tvalid = 1'b0;
    chk("bp_count", DW'(rxq.size()), DW'(20));
    for (int i = 0; i < 20; i++) begin
      chk("bp_word", (i < rxq.size()) ? rxq[i] : DW'(0), DW'(101 + i));
    end
    chk("bp_cnt", DW'(underflow_cnt), DW'(2 * CE));

    // Full: downstream stalled, offer 70 words, exactly 64 taken.
    m_if.tready = 1'b0;
    idx = 0;
    for (int c = 0; c < 70; c++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = DW'(201 + idx);
      acc = s_if.tready;
      tick;
      if (acc) idx++;
    end
    s_if.tvalid = 1'b0;
    chk("full_fill", DW'(fill_level), DW'(64));
    chk("full_sready", DW'(s_if.tready), DW'(0));
    chk("full_accepted", DW'(idx), DW'(64));
    chk("full_state", DW'(state), DW'(2));

    // Drain: pop down to level 5, then drop enable.
    m_if.tready = 1'b1;
    repeat (59) tick;
    chk("pre_drain_fill", DW'(fill_level), DW'(5));
    chk("pre_drain_word", m_if.tdata, DW'(259));
    enable = 1'b0;
    tick;
    chk("drain_state", DW'(state), DW'(3));
    chk("drain_word", m_if.tdata, DW'(260));
    enable = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      tick;
      chk("drain_word", m_if.tdata, DW'(259 + k));
      chk("drain_hold", DW'(state), DW'(3));
    end
    tick;
    chk("drain_idle", DW'(state), DW'(0));
    chk("drain_mvalid", DW'(m_if.tvalid), DW'(0));
    chk("drain_zero", m_if.tdata, DW'(0));
    chk("drain_cnt", DW'(underflow_cnt), DW'(2 * CE));
    tick;
    chk("reen_state", DW'(state), DW'(1));

    // Underflow coinciding with a push, thresh=1.
    prefill_thresh = LVL_W'(1);
    s_if.tvalid    = 1'b1;
    s_if.tdata     = DW'(301);
    tick;
    s_if.tvalid = 1'b0;
    chk("uf_fill1", DW'(fill_level), DW'(1));
    chk("uf_prefill", DW'(state), DW'(1));
    tick;
    chk("uf_run", DW'(state), DW'(2));
    chk("uf_zero", m_if.tdata, DW'(0));
    tick;
    chk("uf_word", m_if.tdata, DW'(301));
    chk("uf_fill0", DW'(fill_level), DW'(0));
    s_if.tvalid = 1'b1;
    s_if.tdata  = DW'(302);
    tick;
    s_if.tvalid = 1'b0;
    chk("ufp_zero", m_if.tdata, DW'(0));
    chk("ufp_fill", DW'(fill_level), DW'(1));
    chk("ufp_state", DW'(state), DW'(1));
    chk("ufp_cnt", DW'(underflow_cnt), DW'(3 * CE));
    chk("ufp_sticky", DW'(underflow_sticky), DW'(CE));
    tick;
    chk("ufp_rerun", DW'(state), DW'(2));
    tick;
    chk("ufp_word", m_if.tdata, DW'(302));
    chk("ufp_fill0", DW'(fill_level), DW'(0));

    // Underflow with a same-cycle clear; threshold 0 behaves as 1.
    prefill_thresh = LVL_W'(0);
    s_if.tvalid    = 1'b1;
    s_if.tdata     = DW'(303);
    underflow_clr  = 1'b1;
    tick;
    underflow_clr = 1'b0;
    s_if.tvalid   = 1'b0;
    chk("clr_cnt", DW'(underflow_cnt), DW'(0));
    chk("clr_sticky", DW'(underflow_sticky), DW'(0));
    chk("clr_fill", DW'(fill_level), DW'(1));
    chk("clr_state", DW'(state), DW'(1));
    tick;
    chk("thr0_run", DW'(state), DW'(2));

    // Reset mid-RUN with 30 words buffered.
    m_if.tready = 1'b0;
    s_if.tvalid = 1'b1;
    for (int i = 0; i < 29; i++) begin
      s_if.tdata = DW'(401 + i);
      tick;
    end
    m_if.tready = 1'b1;
    s_if.tdata  = DW'(430);
    tick;
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b0;
    chk("prerst_fill", DW'(fill_level), DW'(30));
    chk("prerst_word", m_if.tdata, DW'(303));
    chk("prerst_state", DW'(state), DW'(2));
    rf_rstb = 1'b0;
    tick;
    chk_reset_vals("rst1");
    rf_rstb = 1'b1;
    tick;
    chk("postrst_state", DW'(state), DW'(1));
    chk("postrst_fill", DW'(fill_level), DW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
